// File: rtl/qos_wrr_arb.sv
// Weighted round-robin merge of four QoS FIFOs into one registered egress stream.
// Pops are issued from a registered request, masked by live empty/dest_full flags.
module qos_wrr_arb #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        weight0,
  input  logic [2:0]        weight1,
  input  logic [2:0]        weight2,
  input  logic [2:0]        weight3,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] fifo_dataout0,
  input  logic [DATA_W-1:0] fifo_dataout1,
  input  logic [DATA_W-1:0] fifo_dataout2,
  input  logic [DATA_W-1:0] fifo_dataout3,
  input  logic              dest_full,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        chan_out,
  output logic              valid_out,
  output logic              active_out,
  output logic              idle_out
);

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        wgt_q  [4];
  logic [2:0]        cred_q [4];
  logic [2:0]        cred_d [4];
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        req_q, req_d;
  logic              s1_vld_q;
  logic [1:0]        s1_ch_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        chan_q;
  logic              valid_q, active_q, idle_q;

  logic [2:0]        w_in    [4];
  logic [DATA_W-1:0] word_in [4];
  logic [3:0]        pop_vec;
  logic              pop_any, in_flight, found;
  logic [2:0]        cnt;

  assign w_in[0]    = weight0;
  assign w_in[1]    = weight1;
  assign w_in[2]    = weight2;
  assign w_in[3]    = weight3;
  assign word_in[0] = fifo_dataout0;
  assign word_in[1] = fifo_dataout1;
  assign word_in[2] = fifo_dataout2;
  assign word_in[3] = fifo_dataout3;

  // The request is one cycle old, so its empty flag may be stale; the live
  // flags gate it so a just-drained FIFO or a fresh dest_full never sees a pop.
  assign pop_vec   = req_q & ~empty & {4{~dest_full}};
  assign pop_any   = |pop_vec;
  assign in_flight = pop_any | s1_vld_q;
  assign cnt       = (cred_q[ptr_q] == 3'd7) ? 3'd7 : cred_q[ptr_q] + {2'b00, pop_any};

  assign {pop3, pop2, pop1, pop0} = pop_vec;
  assign data_out   = data_q;
  assign chan_out   = chan_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;
  assign idle_out   = idle_q;

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      unique case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (!(&empty) && !dest_full) state_d = ST_ACTIVE;
        ST_ACTIVE: if ((&empty) && !in_flight) state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    req_d = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cred_d[i] = cred_q[i];
    cred_d[ptr_q] = cnt;
    if (state_d == ST_ACTIVE && !dest_full) begin
      if (cnt < wgt_q[ptr_q] && !empty[ptr_q]) begin
        req_d[ptr_q] = 1'b1;
      end else begin
        // i == 4 wraps back to the current channel as the last candidate.
        for (int unsigned i = 1; i <= 4; i++) begin
          if (!found && !empty[ptr_q + 2'(i)]) begin
            found = 1'b1;
            ptr_d = ptr_q + 2'(i);
          end
        end
        if (found) begin
          cred_d[ptr_d] = '0;
          req_d[ptr_d]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      ptr_q    <= '0;
      req_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        cred_q[i] <= '0;
        wgt_q[i]  <= 3'd1;
      end
    end else begin
      state_q  <= state_d;
      active_q <= (state_d == ST_ACTIVE);
      idle_q   <= (state_d == ST_IDLE);
      if (state_q == ST_INIT) begin
        for (int unsigned i = 0; i < 4; i++) wgt_q[i] <= (w_in[i] == 3'd0) ? 3'd1 : w_in[i];
      end
      if (state_d == ST_INIT) begin
        ptr_q    <= '0;
        req_q    <= '0;
        s1_vld_q <= 1'b0;
        valid_q  <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) cred_q[i] <= '0;
      end else begin
        ptr_q    <= ptr_d;
        req_q    <= req_d;
        s1_vld_q <= pop_any;
        s1_ch_q  <= ptr_q;
        valid_q  <= s1_vld_q;
        for (int unsigned i = 0; i < 4; i++) cred_q[i] <= cred_d[i];
        if (s1_vld_q) begin
          data_q <= word_in[s1_ch_q];
          chan_q <= s1_ch_q;
        end
      end
    end
  end

endmodule
